// File: rtl/tile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tile_pkg
// Brief    : Shared screen/tile constants and the tile scheduler state
//            encoding. The tile drawer shares the screen constants.
// Revision : 1.0 - initial release
// ============================================================================
package tile_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int TILE_W   = 8;

  // 3-bit state encodings for the frame sequencer
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_FETCH   = 3'd1;
  localparam logic [2:0] ST_LATCH   = 3'd2;
  localparam logic [2:0] ST_ISSUE   = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;
  localparam logic [2:0] ST_ADVANCE = 3'd5;
  localparam logic [2:0] ST_DONE    = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_FETCH   = ST_FETCH,
    S_LATCH   = ST_LATCH,
    S_ISSUE   = ST_ISSUE,
    S_RELEASE = ST_RELEASE,
    S_ADVANCE = ST_ADVANCE,
    S_DONE    = ST_DONE
  } state_e;

endpackage
`default_nettype wire

// File: rtl/tile_grid_counter.sv
`default_nettype none
// ============================================================================
// Module   : tile_grid_counter
// Brief    : Row-major column/row counter over a COLS x ROWS tile grid with
//            clear, advance and wrap, plus a last-tile flag.
// Revision : 1.0 - initial release
// ============================================================================
module tile_grid_counter #(
  parameter int COLS  = 20,
  parameter int ROWS  = 15,
  parameter int COL_W = $clog2(COLS),
  parameter int ROW_W = $clog2(ROWS)
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             clear,
  input  logic             advance,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             last_tile
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;

  // Next position: clear wins over advance; column wraps into the next row
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear) begin
      col_d = '0;
      row_d = '0;
    end else if (advance) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Position registers
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col       = col_q;
  assign row       = row_q;
  assign last_tile = (col_q == COL_LAST) && (row_q == ROW_LAST);

endmodule
`default_nettype wire

// File: rtl/tile_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tile_scheduler
// Brief    : Frame sequencer for the 8x8 tile drawer. Walks the screen tile
//            grid row-major, fetches each tile index from the tilemap RAM at
//            a scrolled column, and runs the drawer Enable/Done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tile_scheduler #(
  parameter int COLS     = 20,
  parameter int ROWS     = 15,
  parameter int TILE_W   = tile_pkg::TILE_W,
  parameter int MAP_COLS = 64,
  parameter int MAP_AW   = 10,
  parameter int SEL_W    = 4
) (
  input  logic                        Clock,
  input  logic                        Resetn,
  input  logic                        Start,
  input  logic [$clog2(MAP_COLS)-1:0] ScrollCol,
  output logic [MAP_AW-1:0]           MapAddr,
  input  logic [SEL_W-1:0]            MapData,
  output logic [7:0]                  TileX,
  output logic [6:0]                  TileY,
  output logic [SEL_W-1:0]            TileSel,
  output logic                        TileEnable,
  input  logic                        TileDone,
  output logic                        Busy,
  output logic                        FrameDone
);

  import tile_pkg::*;

  localparam int SCROLL_W = $clog2(MAP_COLS);
  localparam int COL_W    = $clog2(COLS);
  localparam int ROW_W    = $clog2(ROWS);

  state_e              state_q, state_d;
  logic [SCROLL_W-1:0] scroll_q, scroll_d;
  logic [SEL_W-1:0]    tile_sel_q, tile_sel_d;

  logic                grid_clear;
  logic                grid_advance;
  logic                last_tile;
  logic [COL_W-1:0]    col;
  logic [ROW_W-1:0]    row;
  logic [SCROLL_W-1:0] map_col;

  tile_grid_counter #(
    .COLS  (COLS),
    .ROWS  (ROWS),
    .COL_W (COL_W),
    .ROW_W (ROW_W)
  ) u_grid (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .clear     (grid_clear),
    .advance   (grid_advance),
    .col       (col),
    .row       (row),
    .last_tile (last_tile)
  );

  // State, scroll latch and tile index registers
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q    <= S_IDLE;
      scroll_q   <= '0;
      tile_sel_q <= '0;
    end else begin
      state_q    <= state_d;
      scroll_q   <= scroll_d;
      tile_sel_q <= tile_sel_d;
    end
  end

  // Sequencer: next state, grid control and handshake outputs
  always_comb begin
    state_d      = state_q;
    scroll_d     = scroll_q;
    tile_sel_d   = tile_sel_q;
    grid_clear   = 1'b0;
    grid_advance = 1'b0;
    TileEnable   = 1'b0;
    FrameDone    = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Scroll is captured only here, so changes mid-frame are ignored
        if (Start) begin
          scroll_d   = ScrollCol;
          grid_clear = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        // RAM data for the address presented in FETCH is valid now
        tile_sel_d = MapData;
        state_d    = S_ISSUE;
      end
      S_ISSUE: begin
        TileEnable = 1'b1;
        if (TileDone) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        // Drawer holds Done until it sees Enable low; wait for it to clear
        if (!TileDone) state_d = S_ADVANCE;
      end
      S_ADVANCE: begin
        if (last_tile) begin
          state_d = S_DONE;
        end else begin
          grid_advance = 1'b1;
          state_d      = S_FETCH;
        end
      end
      S_DONE: begin
        FrameDone = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Position outputs derived from the registered grid and scroll; zero when idle
  always_comb begin
    map_col = scroll_q + SCROLL_W'(col);
    MapAddr = '0;
    TileX   = '0;
    TileY   = '0;
    if (Busy) begin
      MapAddr = MAP_AW'(row) * MAP_AW'(MAP_COLS) + MAP_AW'(map_col);
      TileX   = 8'(col) * 8'(TILE_W);
      TileY   = 7'(row) * 7'(TILE_W);
    end
  end

  assign Busy    = (state_q != S_IDLE);
  assign TileSel = tile_sel_q;

endmodule
`default_nettype wire

// File: tb/tb_tile_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_tile_scheduler
// Brief    : Directed self-checking bench for tile_scheduler with a stub
//            tilemap RAM and a stub tile drawer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tile_scheduler;

  logic       Clock = 1'b0;
  logic       Resetn = 1'b0;
  logic       Start = 1'b0;
  logic [5:0] ScrollCol = '0;
  logic [9:0] MapAddr;
  logic [3:0] MapData = '0;
  logic [7:0] TileX;
  logic [6:0] TileY;
  logic [3:0] TileSel;
  logic       TileEnable;
  logic       TileDone = 1'b0;
  logic       Busy;
  logic       FrameDone;

  int vectors = 0;
  int miscompares = 0;

  tile_scheduler dut (
    .Clock      (Clock),
    .Resetn     (Resetn),
    .Start      (Start),
    .ScrollCol  (ScrollCol),
    .MapAddr    (MapAddr),
    .MapData    (MapData),
    .TileX      (TileX),
    .TileY      (TileY),
    .TileSel    (TileSel),
    .TileEnable (TileEnable),
    .TileDone   (TileDone),
    .Busy       (Busy),
    .FrameDone  (FrameDone)
  );

  always #5 Clock = ~Clock;

  // Tilemap contents: a fixed scramble of the address
  function automatic logic [3:0] ram_val(input logic [9:0] a);
    return a[3:0] ^ a[7:4] ^ {2'b00, a[9:8]};
  endfunction

  // Synchronous tilemap RAM: data valid the cycle after the address
  always @(posedge Clock) MapData <= ram_val(MapAddr);

  // Stub drawer: Done 4 cycles after Enable, released done_hold cycles after Enable drops
  int done_hold = 0;
  int en_cnt = 0;
  int rel_cnt = 0;
  always @(posedge Clock) begin
    if (!Resetn) begin
      en_cnt   <= 0;
      rel_cnt  <= 0;
      TileDone <= 1'b0;
    end else if (TileEnable) begin
      rel_cnt <= 0;
      if (en_cnt == 3) TileDone <= 1'b1;
      else             en_cnt   <= en_cnt + 1;
    end else begin
      en_cnt <= 0;
      if (TileDone) begin
        if (rel_cnt >= done_hold) TileDone <= 1'b0;
        else                      rel_cnt  <= rel_cnt + 1;
      end
    end
  end

  // Record every Enable pulse's tile info, and count FrameDone pulses
  logic       en_prev = 1'b0;
  int         n_pulse = 0;
  int         n_fd = 0;
  logic [7:0] p_x    [0:2047];
  logic [6:0] p_y    [0:2047];
  logic [9:0] p_addr [0:2047];
  logic [3:0] p_sel  [0:2047];
  always @(negedge Clock) begin
    en_prev <= TileEnable;
    if (TileEnable && !en_prev) begin
      if (n_pulse < 2048) begin
        p_x[n_pulse]    <= TileX;
        p_y[n_pulse]    <= TileY;
        p_addr[n_pulse] <= MapAddr;
        p_sel[n_pulse]  <= TileSel;
      end
      n_pulse <= n_pulse + 1;
    end
    if (FrameDone) n_fd <= n_fd + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issue a one-cycle Start from IDLE
  task automatic start_frame(input logic [5:0] scroll);
    @(negedge Clock);
    Start     = 1'b1;
    ScrollCol = scroll;
    @(negedge Clock);
    Start = 1'b0;
  endtask

  task automatic wait_frame_done(input int limit);
    for (int i = 0; i < limit && !FrameDone; i++) @(negedge Clock);
    check("frame_done_seen", FrameDone, 1);
  endtask

  task automatic wait_enable(input int limit);
    for (int i = 0; i < limit && !TileEnable; i++) @(negedge Clock);
    check("enable_seen", TileEnable, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int base;
  int fd_base;

  initial begin
    // ---------------- Reset with Start held high ----------------
    Resetn = 1'b0;
    Start  = 1'b1;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    check("rst_enable", TileEnable, 0);
    check("rst_addr",   MapAddr,    0);
    check("rst_x",      TileX,      0);
    check("rst_y",      TileY,      0);
    check("rst_sel",    TileSel,    0);
    check("rst_busy",   Busy,       0);
    check("rst_fdone",  FrameDone,  0);

    // ---------------- Frame 1: scroll 0 ----------------
    base    = n_pulse;
    fd_base = n_fd;
    Resetn  = 1'b1;
    @(negedge Clock);
    check("busy_after_rst", Busy, 1);
    check("f1_fetch_addr",  MapAddr, 0);
    Start = 1'b0;
    wait_frame_done(5000);
    check("f1_busy_at_fd", Busy, 1);
    @(negedge Clock);
    check("f1_busy_fell",  Busy, 0);
    check("f1_fd_pulse",   FrameDone, 0);
    check("f1_idle_addr",  MapAddr, 0);
    check("f1_fd_count",   n_fd - fd_base, 1);
    check("f1_pulses",     n_pulse - base, 300);
    check("f1_first_x",    p_x[base], 0);
    check("f1_first_y",    p_y[base], 0);
    check("f1_first_addr", p_addr[base], 0);
    check("f1_first_sel",  p_sel[base], ram_val(10'd0));
    check("f1_last_x",     p_x[base+299], 152);
    check("f1_last_y",     p_y[base+299], 112);
    check("f1_last_addr",  p_addr[base+299], 915);
    check("f1_last_sel",   p_sel[base+299], ram_val(10'd915));

    // ---------------- Frame 2: column wrap with scroll 60 ----------------
    base = n_pulse;
    start_frame(6'd60);
    wait_frame_done(5000);
    @(negedge Clock);
    check("wr_pulses",   n_pulse - base, 300);
    check("wr_c3_addr",  p_addr[base+3], 63);
    check("wr_c3_sel",   p_sel[base+3], ram_val(10'd63));
    check("wr_c4_addr",  p_addr[base+4], 0);
    check("wr_c4_sel",   p_sel[base+4], ram_val(10'd0));
    check("wr_c5_addr",  p_addr[base+5], 1);
    check("wr_c5_sel",   p_sel[base+5], ram_val(10'd1));
    check("wr_c5_x",     p_x[base+5], 40);
    check("wr_r1c4_addr", p_addr[base+24], 64);
    check("wr_r1c4_sel", p_sel[base+24], ram_val(10'd64));
    check("wr_r1c4_y",   p_y[base+24], 8);

    // ---------------- Frame 3: drawer holds Done after Enable drops ----------------
    done_hold = 5;
    base = n_pulse;
    start_frame(6'd0);
    wait_enable(50);
    for (int i = 0; i < 50 && TileEnable; i++) @(negedge Clock);
    check("hs_enable_fell", TileEnable, 0);
    check("hs_done_held",   TileDone, 1);
    for (int i = 0; i < 20 && TileDone; i++) begin
      check("hs_enable_low", TileEnable, 0);
      check("hs_addr_hold",  MapAddr, 0);
      @(negedge Clock);
    end
    check("hs_done_fell",  TileDone, 0);
    check("hs_addr_rel",   MapAddr, 0);
    @(negedge Clock);
    check("hs_addr_adv",   MapAddr, 0);
    check("hs_enable_adv", TileEnable, 0);
    @(negedge Clock);
    check("hs_addr_next",  MapAddr, 1);
    wait_frame_done(8000);
    @(negedge Clock);
    check("hs_pulses",     n_pulse - base, 300);
    check("hs_t1_addr",    p_addr[base+1], 1);
    done_hold = 0;

    // ---------------- Frame 4: Start while busy is ignored ----------------
    base    = n_pulse;
    fd_base = n_fd;
    start_frame(6'd10);
    for (int i = 0; i < 1000 && (n_pulse - base) < 30; i++) @(negedge Clock);
    ScrollCol = 6'd33;
    Start     = 1'b1;
    repeat (3) @(negedge Clock);
    Start = 1'b0;
    wait_frame_done(5000);
    @(negedge Clock);
    check("sb_pulses",    n_pulse - base, 300);
    check("sb_fd_count",  n_fd - fd_base, 1);
    check("sb_r1c9_addr", p_addr[base+29], 83);
    check("sb_r2c0_addr", p_addr[base+40], 138);
    check("sb_last_addr", p_addr[base+299], 925);
    check("sb_busy_low",  Busy, 0);
    @(negedge Clock);
    check("sb_no_restart", Busy, 0);

    // ---------------- Frame 5: reset during ISSUE at tile (7,3) ----------------
    base = n_pulse;
    start_frame(6'd0);
    for (int i = 0; i < 2000 && !(TileEnable && (n_pulse - base) == 68); i++) @(negedge Clock);
    check("mr_enable",   TileEnable, 1);
    check("mr_x",        TileX, 56);
    check("mr_y",        TileY, 24);
    check("mr_addr",     MapAddr, 199);
    Resetn = 1'b0;
    @(negedge Clock);
    check("mr_enable_drop", TileEnable, 0);
    check("mr_busy",        Busy, 0);
    check("mr_addr_zero",   MapAddr, 0);
    check("mr_x_zero",      TileX, 0);
    check("mr_sel_zero",    TileSel, 0);
    @(negedge Clock);
    Resetn = 1'b1;
    @(negedge Clock);
    check("mr_idle_after", Busy, 0);
    base = n_pulse;
    start_frame(6'd0);
    wait_enable(50);
    @(negedge Clock);
    check("mr_new_pulses", n_pulse - base, 1);
    check("mr_new_x",      p_x[base], 0);
    check("mr_new_y",      p_y[base], 0);
    check("mr_new_addr",   p_addr[base], 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
